// File: rtl/prefix_add_seq32.sv
// Sequential byte-sliced adder: one 8-bit slice per cycle, valid/ready on both sides.
// Define PREFIX_ADD_OVF_EN to add the signed-overflow output ovf.
module prefix_add_seq32 #(
  parameter int BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*BYTES-1:0]   a,
  input  logic [8*BYTES-1:0]   b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*BYTES-1:0]   sum,
  output logic                 cout
`ifdef PREFIX_ADD_OVF_EN
  ,
  output logic                 ovf
`endif
);

  localparam int W  = 8 * BYTES;
  localparam int CW = $clog2(BYTES + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [W-1:0]  ra;
  logic [W-1:0]  rb;
  logic          carry;
  logic [CW-1:0] cnt;
  logic [8:0]    slice;

  // Operands shift down so the current slice is always in the low byte.
  always_comb begin
    slice = {1'b0, ra[7:0]} + {1'b0, rb[7:0]} + {8'd0, carry};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ra        <= '0;
      rb        <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
`ifdef PREFIX_ADD_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            ra       <= a;
            rb       <= b;
            carry    <= cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (cnt == CW'(BYTES)) begin
            cout      <= carry;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            for (int k = 0; k < BYTES; k++) begin
              if (cnt == CW'(k)) begin
                sum[8*k +: 8] <= slice[7:0];
              end
            end
`ifdef PREFIX_ADD_OVF_EN
            // carry into the sign bit xor carry out of it
            if (cnt == CW'(BYTES - 1)) begin
              ovf <= ra[7] ^ rb[7] ^ slice[7] ^ slice[8];
            end
`endif
            carry <= slice[8];
            ra    <= ra >> 8;
            rb    <= rb >> 8;
            cnt   <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prefix_add_seq32.sv
// Directed self-checking bench for prefix_add_seq32 (BYTES = 4).
// Checks ovf only when PREFIX_ADD_OVF_EN is defined.
module tb_prefix_add_seq32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
`ifdef PREFIX_ADD_OVF_EN
  logic        ovf;
`endif

  int tests;
  int fails;

  prefix_add_seq32 #(.BYTES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PREFIX_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand set and wait for out_valid; lat = cycles after accept.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                       input logic c, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    a = x;
    b = y;
    cin = c;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    lat = out_valid ? n : 99;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_out_valid got %b exp 0", out_valid);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
    tests++;
    if (sum !== 32'h0) begin
      fails++;
      $display("FAIL reset_sum got %h exp 00000000", sum);
    end
    tests++;
    if (cout !== 1'b0) begin
      fails++;
      $display("FAIL reset_cout got %b exp 0", cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    a = 32'h12345678;
    b = 32'h11111111;
    cin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_in_ready_run got %b exp 0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    tests++;
    if (lat !== 5) begin
      fails++;
      $display("FAIL basic_latency got %0d exp 5", lat);
    end
    tests++;
    if (sum !== 32'h23456789) begin
      fails++;
      $display("FAIL basic_sum got %h exp 23456789", sum);
    end
    tests++;
    if (cout !== 1'b0) begin
      fails++;
      $display("FAIL basic_cout got %b exp 0", cout);
    end
    consume();
  endtask

  task automatic test_ripple();
    int lat;
    do_op(32'hFFFFFFFF, 32'h00000000, 1'b1, lat);
    tests++;
    if (lat !== 5) begin
      fails++;
      $display("FAIL ripple_latency got %0d exp 5", lat);
    end
    tests++;
    if (sum !== 32'h00000000) begin
      fails++;
      $display("FAIL ripple_sum got %h exp 00000000", sum);
    end
    tests++;
    if (cout !== 1'b1) begin
      fails++;
      $display("FAIL ripple_cout got %b exp 1", cout);
    end
`ifdef PREFIX_ADD_OVF_EN
    tests++;
    if (ovf !== 1'b0) begin
      fails++;
      $display("FAIL ripple_ovf got %b exp 0", ovf);
    end
`endif
    consume();
  endtask

  task automatic test_overflow();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic        vc [3];
    logic [31:0] es [3];
    logic        ec [3];
    logic        eo [3];
    int lat;
    va[0] = 32'h7FFFFFFF; vb[0] = 32'h00000001; vc[0] = 1'b0;
    es[0] = 32'h80000000; ec[0] = 1'b0; eo[0] = 1'b1;
    va[1] = 32'h80000000; vb[1] = 32'h80000000; vc[1] = 1'b0;
    es[1] = 32'h00000000; ec[1] = 1'b1; eo[1] = 1'b1;
    va[2] = 32'hFFFFFFFF; vb[2] = 32'hFFFFFFFF; vc[2] = 1'b1;
    es[2] = 32'hFFFFFFFF; ec[2] = 1'b1; eo[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], vc[i], lat);
      tests++;
      if (sum !== es[i]) begin
        fails++;
        $display("FAIL ovf_vec%0d_sum got %h exp %h", i, sum, es[i]);
      end
      tests++;
      if (cout !== ec[i]) begin
        fails++;
        $display("FAIL ovf_vec%0d_cout got %b exp %b", i, cout, ec[i]);
      end
`ifdef PREFIX_ADD_OVF_EN
      tests++;
      if (ovf !== eo[i]) begin
        fails++;
        $display("FAIL ovf_vec%0d_ovf got %b exp %b", i, ovf, eo[i]);
      end
`endif
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    do_op(32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      a = ~a;
      b = $urandom;
      cin = ~cin;
      in_valid = ~in_valid;
      tick();
      tests++;
      if (sum !== 32'hB4B4B4B4 || cout !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold%0d got %h/%b exp b4b4b4b4/0", i, sum, cout);
      end
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_flags%0d got ov=%b ir=%b exp ov=1 ir=0",
                 i, out_valid, in_ready);
      end
    end
    in_valid = 1'b0;
    consume();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release got ov=%b ir=%b exp ov=0 ir=1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    a = 32'hFFFFFFFF;
    b = 32'h00000001;
    cin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || sum !== 32'h0 || cout !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_clear got ov=%b sum=%h co=%b exp 0/0/0",
               out_valid, sum, cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_idle got ir=%b ov=%b exp ir=1 ov=0",
               in_ready, out_valid);
    end
    do_op(32'h1, 32'h2, 1'b0, lat);
    tests++;
    if (lat !== 5) begin
      fails++;
      $display("FAIL rstmid_latency got %0d exp 5", lat);
    end
    tests++;
    if (sum !== 32'h3 || cout !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_sum got %h/%b exp 00000003/0", sum, cout);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [31:0] res [2];
    int rcy [2];
    int acy [2];
    int nres;
    int nacc;
    logic take;
    res[0] = '0; res[1] = '0;
    rcy[0] = 0; rcy[1] = 0;
    acy[0] = 0; acy[1] = 0;
    nres = 0;
    nacc = 0;
    a = 32'h0000FFFF;
    b = 32'h00000001;
    cin = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) begin
        if (nres < 2) begin
          res[nres] = sum;
          rcy[nres] = i;
        end
        nres++;
      end
      take = in_valid && in_ready;
      if (take) begin
        if (nacc < 2) acy[nacc] = i;
        nacc++;
      end
      tick();
      if (take) begin
        if (nacc == 1) begin
          a = 32'h12345678;
          b = 32'h87654321;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    tests++;
    if (nacc !== 2 || nres !== 2) begin
      fails++;
      $display("FAIL b2b_counts got acc=%0d res=%0d exp 2/2", nacc, nres);
    end
    tests++;
    if (res[0] !== 32'h00010000) begin
      fails++;
      $display("FAIL b2b_res0 got %h exp 00010000", res[0]);
    end
    tests++;
    if (res[1] !== 32'h99999999) begin
      fails++;
      $display("FAIL b2b_res1 got %h exp 99999999", res[1]);
    end
    tests++;
    if (rcy[0] !== acy[0] + 6) begin
      fails++;
      $display("FAIL b2b_lat0 got %0d exp %0d", rcy[0], acy[0] + 6);
    end
    tests++;
    if (acy[1] !== rcy[0] + 1) begin
      fails++;
      $display("FAIL b2b_gap got %0d exp %0d", acy[1], rcy[0] + 1);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    test_reset();
    test_basic();
    test_ripple();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prefix_add_seq32.md
PREFIX_ADD_SEQ32 -- requirements
Module: prefix_add_seq32

Interface
REQ-001 SHALL provide parameter: BYTES, 4, number of 8-bit slices per operand (operand width W = 8*BYTES; legal range 2..8).
REQ-002 SHALL provide port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide ports: in_valid  input  1  operands valid; in_ready  output  1  block can accept operands.
REQ-005 SHALL provide ports: a  input  W  operand A; b  input  W  operand B; cin  input  1  carry-in.
REQ-006 SHALL provide ports: out_valid  output  1  result valid; out_ready  input  1  consumer accepts result.
REQ-007 SHALL provide ports: sum  output  W  a+b+cin modulo 2^W; cout  output  1  carry out of bit W-1.

Function
REQ-008 SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-009 SHALL assert in_ready only in IDLE; out_valid only in DONE.
REQ-010 SHALL, on in_valid && in_ready, capture a, b, cin into internal registers, clear slice counter to 0, go IDLE->RUN.
REQ-011 SHALL, in RUN, add one 8-bit slice per cycle, LSB slice first: slice k = a[8k+7:8k] + b[8k+7:8k] + carry, 9-bit result.
REQ-012 SHALL write the low 8 bits of slice k into sum[8k+7:8k] and register bit 8 as carry for slice k+1; the carry for slice 0 is captured cin.
REQ-013 SHALL go RUN->DONE after slice BYTES-1 completes, with cout = carry out of final slice; latency from accept to out_valid = BYTES+1 cycles (5 for default).
REQ-014 SHALL hold sum, cout, out_valid stable in DONE while out_ready is low (no result loss under backpressure).
REQ-015 SHALL go DONE->IDLE on out_valid && out_ready; in_ready rises the following cycle (no same-cycle accept in DONE).
REQ-016 SHALL ignore a, b, cin, in_valid in RUN and DONE; input changes after acceptance never affect the result.
REQ-017 SHALL ignore out_ready outside DONE.
REQ-018 SHALL produce full wrap-around: all-ones + 1 gives sum = 0, cout = 1.
REQ-019 SHALL leave upper sum slices unchanged from the previous result until overwritten during RUN; sum is defined only while out_valid is high.

Reset
REQ-020 SHALL, on rst_n low, asynchronously force state = IDLE, slice counter = 0, carry = 0, sum = 0, cout = 0, out_valid = 0, in_ready = 1 (after release).
REQ-021 SHALL, on reset asserted mid-RUN or in DONE, abandon the operation with no result delivered.
REQ-022 SHALL begin normal operation on the first rising clk edge after rst_n deasserts.

Configuration
REQ-023 SHALL support macro PREFIX_ADD_OVF_EN: when defined, add output port ovf  output  1, signed overflow = carry into bit W-1 XOR cout, valid with out_valid, reset 0, held under backpressure.
REQ-024 SHALL, when PREFIX_ADD_OVF_EN is undefined, omit the ovf port and its logic entirely; all other behaviour identical.

Verification
REQ-025 SHALL cover basic add: a=0x12345678, b=0x11111111, cin=0 -> sum=0x23456789, cout=0, out_valid exactly 5 cycles after accept.
REQ-026 SHALL cover full carry ripple: a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1 (ovf=0 with macro).
REQ-027 SHALL cover signed overflow: a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1 with macro.
REQ-028 SHALL cover backpressure: hold out_ready=0 for 10 cycles in DONE, toggle a/b/in_valid -> sum/cout stable, in_ready=0 throughout; result accepted on out_ready=1, in_ready=1 next cycle.
REQ-029 SHALL cover reset mid-operation: assert rst_n=0 two cycles into RUN -> out_valid=0, sum=0, in_ready=1 after release; next operation a=1, b=2 -> sum=3.
REQ-030 SHALL cover back-to-back operations with in_valid held high: two operand pairs accepted, each result delivered once, in order, with one idle cycle between DONE exit and next accept.
